// File: rtl/control_fsm.sv
// Multicycle control unit for the 16-bit processor: fetch/decode/execute/memory/writeback
// sequencing over S0-S11. Optional memory-wait timeout enabled by `define CTRL_MEM_TIMEOUT_EN.
module control_fsm #(
  parameter logic [15:0] TRAP_VECTOR    = 16'h0010,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] instr,
  input  logic        zero,
  input  logic        mem_ready,
  output logic [3:0]  state,
  output logic        mem_req,
  output logic        mem_we,
  output logic        addr_sel,
  output logic        ir_write,
  output logic        pc_write,
  output logic [1:0]  pc_src,
  output logic [1:0]  alu_op,
  output logic        alu_src_b,
  output logic        reg_write,
  output logic        wb_sel,
  output logic        halted,
  output logic        trap
);

  typedef enum logic [3:0] {
    S0_FETCH   = 4'd0,
    S1_DECODE  = 4'd1,
    S2_EXEC_R  = 4'd2,
    S3_WB_ALU  = 4'd3,
    S4_EXEC_I  = 4'd4,
    S5_ADDR    = 4'd5,
    S6_MEM_RD  = 4'd6,
    S7_MEM_WR  = 4'd7,
    S8_BRANCH  = 4'd8,
    S9_JUMP    = 4'd9,
    S10_HALT   = 4'd10,
    S11_TRAP   = 4'd11
  } state_t;

  state_t     state_q, state_d;
  logic [3:0] opcode;
  logic       timeout;

  assign opcode = instr[15:12];

`ifdef CTRL_MEM_TIMEOUT_EN
  localparam int CNT_W = (TIMEOUT_CYCLES > 255) ? $clog2(TIMEOUT_CYCLES + 1) : 8;

  logic [CNT_W-1:0] wait_cnt;
  logic             unused_bits;

  // Counts consecutive stalled cycles of the current access; any cycle without a stall clears it.
  always_ff @(posedge clk) begin
    if (reset) begin
      wait_cnt <= '0;
    end else if (mem_req && !mem_ready) begin
      wait_cnt <= wait_cnt + CNT_W'(1);
    end else begin
      wait_cnt <= '0;
    end
  end

  assign timeout     = !mem_ready && (wait_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
  assign unused_bits = ^{instr[11:0], TRAP_VECTOR};
`else
  logic unused_bits;

  assign timeout     = 1'b0;
  assign unused_bits = ^{instr[11:0], TRAP_VECTOR, TIMEOUT_CYCLES};
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S0_FETCH;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    addr_sel  = 1'b0;
    ir_write  = 1'b0;
    pc_write  = 1'b0;
    pc_src    = 2'b00;
    alu_op    = 2'b00;
    alu_src_b = 1'b0;
    reg_write = 1'b0;
    wb_sel    = 1'b0;
    halted    = 1'b0;
    trap      = 1'b0;

    unique case (state_q)
      S0_FETCH: begin
        mem_req = 1'b1;
        if (mem_ready) begin
          ir_write = 1'b1;
          pc_write = 1'b1;
          state_d  = S1_DECODE;
        end else if (timeout) begin
          state_d  = S11_TRAP;
        end
      end
      S1_DECODE: begin
        case (opcode)
          4'h0, 4'h1, 4'h2, 4'h3: state_d = S2_EXEC_R;
          4'h4:                   state_d = S4_EXEC_I;
          4'h5, 4'h6:             state_d = S5_ADDR;
          4'h7:                   state_d = S8_BRANCH;
          4'h8:                   state_d = S9_JUMP;
          4'hF:                   state_d = S10_HALT;
          default:                state_d = S11_TRAP;
        endcase
      end
      S2_EXEC_R: begin
        alu_op  = opcode[1:0];
        state_d = S3_WB_ALU;
      end
      S3_WB_ALU: begin
        reg_write = 1'b1;
        state_d   = S0_FETCH;
      end
      S4_EXEC_I: begin
        alu_src_b = 1'b1;
        state_d   = S3_WB_ALU;
      end
      S5_ADDR: begin
        alu_src_b = 1'b1;
        state_d   = (opcode == 4'h5) ? S6_MEM_RD : S7_MEM_WR;
      end
      S6_MEM_RD: begin
        mem_req  = 1'b1;
        addr_sel = 1'b1;
        if (mem_ready) begin
          reg_write = 1'b1;
          wb_sel    = 1'b1;
          state_d   = S0_FETCH;
        end else if (timeout) begin
          state_d   = S11_TRAP;
        end
      end
      S7_MEM_WR: begin
        mem_req  = 1'b1;
        mem_we   = 1'b1;
        addr_sel = 1'b1;
        if (mem_ready) begin
          state_d = S0_FETCH;
        end else if (timeout) begin
          state_d = S11_TRAP;
        end
      end
      S8_BRANCH: begin
        alu_op = 2'b01;
        if (zero) begin
          pc_write = 1'b1;
          pc_src   = 2'b01;
        end
        state_d = S0_FETCH;
      end
      S9_JUMP: begin
        pc_write = 1'b1;
        pc_src   = 2'b10;
        state_d  = S0_FETCH;
      end
      S10_HALT: begin
        halted = 1'b1;
      end
      S11_TRAP: begin
        trap     = 1'b1;
        pc_write = 1'b1;
        pc_src   = 2'b11;
        state_d  = S0_FETCH;
      end
      default: state_d = S0_FETCH;
    endcase

    // Reset silences every strobe in the reset cycle, abandoning any access in flight.
    if (reset) begin
      mem_req   = 1'b0;
      mem_we    = 1'b0;
      addr_sel  = 1'b0;
      ir_write  = 1'b0;
      pc_write  = 1'b0;
      pc_src    = 2'b00;
      alu_op    = 2'b00;
      alu_src_b = 1'b0;
      reg_write = 1'b0;
      wb_sel    = 1'b0;
      halted    = 1'b0;
      trap      = 1'b0;
    end
  end

  assign state = reset ? 4'd0 : state_q;

endmodule

// File: tb/tb_control_fsm.sv
// Directed testbench for control_fsm; expected output words are hand-computed per state.
module tb_control_fsm;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] instr;
  logic        zero;
  logic        mem_ready;
  logic [3:0]  state;
  logic        mem_req, mem_we, addr_sel, ir_write, pc_write;
  logic [1:0]  pc_src, alu_op;
  logic        alu_src_b, reg_write, wb_sel, halted, trap;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  control_fsm #(
    .TRAP_VECTOR    (16'h0010),
    .TIMEOUT_CYCLES (4)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .instr     (instr),
    .zero      (zero),
    .mem_ready (mem_ready),
    .state     (state),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .addr_sel  (addr_sel),
    .ir_write  (ir_write),
    .pc_write  (pc_write),
    .pc_src    (pc_src),
    .alu_op    (alu_op),
    .alu_src_b (alu_src_b),
    .reg_write (reg_write),
    .wb_sel    (wb_sel),
    .halted    (halted),
    .trap      (trap)
  );

  // Output word layout: state, req, we, asel, irw, pcw, pcsrc, aluop, asrcb, rw, wbsel, halt, trap
  logic [17:0] outv;
  assign outv = {state, mem_req, mem_we, addr_sel, ir_write, pc_write, pc_src,
                 alu_op, alu_src_b, reg_write, wb_sel, halted, trap};

  function automatic logic [17:0] pk(input logic [3:0] st, input logic req, input logic we,
                                     input logic as, input logic irw, input logic pcw,
                                     input logic [1:0] pcs, input logic [1:0] aop,
                                     input logic asb, input logic rw, input logic wbs,
                                     input logic hlt, input logic trp);
    return {st, req, we, as, irw, pcw, pcs, aop, asb, rw, wbs, hlt, trp};
  endfunction

  task automatic check(input string tag, input logic [17:0] got, input logic [17:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Inputs are set just after a rising edge; outputs are checked 1ns later, then one clock elapses.
  task automatic cyc(input string tag, input logic [17:0] exp);
    #1;
    check(tag, outv, exp);
    @(posedge clk);
    #1;
  endtask

  logic [17:0] zero_w, fetch_rdy, fetch_wait, dec;

  initial begin
    zero_w     = '0;
    fetch_rdy  = pk(4'd0, 1, 0, 0, 1, 1, 2'b00, 2'b00, 0, 0, 0, 0, 0);
    fetch_wait = pk(4'd0, 1, 0, 0, 0, 0, 2'b00, 2'b00, 0, 0, 0, 0, 0);
    dec        = pk(4'd1, 0, 0, 0, 0, 0, 2'b00, 2'b00, 0, 0, 0, 0, 0);

    reset = 1'b1; instr = 16'h0000; zero = 1'b0; mem_ready = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    cyc("reset_outputs", zero_w);
    reset = 1'b0;

    // ADD
    instr = 16'h0123; mem_ready = 1'b1;
    cyc("add_s0", fetch_rdy);
    cyc("add_s1", dec);
    cyc("add_s2", pk(4'd2, 0, 0, 0, 0, 0, 2'b00, 2'b00, 0, 0, 0, 0, 0));
    cyc("add_s3", pk(4'd3, 0, 0, 0, 0, 0, 2'b00, 2'b00, 0, 1, 0, 0, 0));

    // OR
    instr = 16'h3456;
    cyc("or_s0", fetch_rdy);
    cyc("or_s1", dec);
    cyc("or_s2", pk(4'd2, 0, 0, 0, 0, 0, 2'b00, 2'b11, 0, 0, 0, 0, 0));
    cyc("or_s3", pk(4'd3, 0, 0, 0, 0, 0, 2'b00, 2'b00, 0, 1, 0, 0, 0));

    // ADDI
    instr = 16'h4105;
    cyc("addi_s0", fetch_rdy);
    cyc("addi_s1", dec);
    cyc("addi_s4", pk(4'd4, 0, 0, 0, 0, 0, 2'b00, 2'b00, 1, 0, 0, 0, 0));
    cyc("addi_s3", pk(4'd3, 0, 0, 0, 0, 0, 2'b00, 2'b00, 0, 1, 0, 0, 0));

    // LW with three wait cycles
    instr = 16'h5210;
    cyc("lw_s0", fetch_rdy);
    cyc("lw_s1", dec);
    cyc("lw_s5", pk(4'd5, 0, 0, 0, 0, 0, 2'b00, 2'b00, 1, 0, 0, 0, 0));
    mem_ready = 1'b0;
    for (int i = 0; i < 3; i++)
      cyc("lw_s6_wait", pk(4'd6, 1, 0, 1, 0, 0, 2'b00, 2'b00, 0, 0, 0, 0, 0));
    mem_ready = 1'b1;
    cyc("lw_s6_ready", pk(4'd6, 1, 0, 1, 0, 0, 2'b00, 2'b00, 0, 1, 1, 0, 0));

    // BEQ taken then not taken
    instr = 16'h7124; zero = 1'b1;
    cyc("beq1_s0", fetch_rdy);
    cyc("beq1_s1", dec);
    cyc("beq1_s8", pk(4'd8, 0, 0, 0, 0, 1, 2'b01, 2'b01, 0, 0, 0, 0, 0));
    zero = 1'b0;
    cyc("beq0_s0", fetch_rdy);
    cyc("beq0_s1", dec);
    cyc("beq0_s8", pk(4'd8, 0, 0, 0, 0, 0, 2'b00, 2'b01, 0, 0, 0, 0, 0));

    // JMP
    instr = 16'h8000;
    cyc("jmp_s0", fetch_rdy);
    cyc("jmp_s1", dec);
    cyc("jmp_s9", pk(4'd9, 0, 0, 0, 0, 1, 2'b10, 2'b00, 0, 0, 0, 0, 0));

    // SW, reset during the write wait
    instr = 16'h6300;
    cyc("sw_s0", fetch_rdy);
    cyc("sw_s1", dec);
    cyc("sw_s5", pk(4'd5, 0, 0, 0, 0, 0, 2'b00, 2'b00, 1, 0, 0, 0, 0));
    mem_ready = 1'b0;
    cyc("sw_s7_wait", pk(4'd7, 1, 1, 1, 0, 0, 2'b00, 2'b00, 0, 0, 0, 0, 0));
    reset = 1'b1; mem_ready = 1'b1;
    cyc("sw_reset_cycle", zero_w);
    reset = 1'b0; mem_ready = 1'b0;
    cyc("after_reset_s0", fetch_wait);

    // Illegal opcode
    instr = 16'hA000; mem_ready = 1'b1;
    cyc("ill_s0", fetch_rdy);
    cyc("ill_s1", dec);
    cyc("ill_s11", pk(4'd11, 0, 0, 0, 0, 1, 2'b11, 2'b00, 0, 0, 0, 0, 1));

    // Fetch stall: traps after four wait cycles only when the timeout is built in
    mem_ready = 1'b0;
    for (int i = 0; i < 4; i++)
      cyc("stall_s0", fetch_wait);
`ifdef CTRL_MEM_TIMEOUT_EN
    cyc("timeout_s11", pk(4'd11, 0, 0, 0, 0, 1, 2'b11, 2'b00, 0, 0, 0, 0, 1));
`else
    cyc("no_timeout_s0", fetch_wait);
`endif
    cyc("stall_back_s0", fetch_wait);

    // HLT then reset
    instr = 16'hF000; mem_ready = 1'b1;
    cyc("hlt_s0", fetch_rdy);
    cyc("hlt_s1", dec);
    for (int i = 0; i < 20; i++)
      cyc("hlt_s10", pk(4'd10, 0, 0, 0, 0, 0, 2'b00, 2'b00, 0, 0, 0, 1, 0));
    reset = 1'b1;
    cyc("hlt_reset", zero_w);
    reset = 1'b0; mem_ready = 1'b0;
    cyc("hlt_after_reset", fetch_wait);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
